lfsr_rng_arbiter: RTL

Shares one 8-bit Fibonacci LFSR (taps 7,5,4,3) between NUM_REQ requesters. A round-robin arbiter picks one requester at a time. The selected requester receives a fresh 8-bit value after the register has been advanced STEPS times. A seed-load port reconfigures the register, and a zero seed is never allowed to lock it up. The block sits between the pseudo-random generator datapath and its consumer blocks.

---
 rtl/lfsr_rng_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/lfsr_rng_arbiter.sv
// One 8-bit Fibonacci LFSR (taps 7,5,4,3) shared round-robin among NUM_REQ requesters.
// Each grant delivers the register value after it has been advanced STEPS times.
module lfsr_rng_arbiter #(
    parameter int         NUM_REQ = 4,
    parameter int         STEPS   = 8,
    parameter logic [7:0] SEED    = 8'hAA
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               seed_load,
    input  logic [7:0]         seed_in,
    output logic [NUM_REQ-1:0] gnt,
    output logic [7:0]         rnd_out,
    output logic               rnd_valid,
    output logic               busy
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Handshake: req[i] is a level request held until its own gnt[i]; gnt[i] and
    // rnd_valid pulse together for one cycle and that cycle is the transfer.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STEP    = 2'd1,
        DELIVER = 2'd2
    } state_t;

    state_t             state;
    logic [7:0]         lfsr;
    logic [7:0]         cnt;
    logic [IW-1:0]      last;
    logic [IW-1:0]      winner;
    logic [IW-1:0]      pick;
    logic               pick_valid;
    logic [NUM_REQ-1:0] winner_oh;

    function automatic logic [7:0] lfsr_step(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    // Round-robin search starts just after the last granted requester.
    always_comb begin
        int j;
        j          = 0;
        pick       = '0;
        pick_valid = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            j = int'(last) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!pick_valid && req[j]) begin
                pick_valid = 1'b1;
                pick       = IW'(j);
            end
        end
    end

    always_comb begin
        winner_oh         = '0;
        winner_oh[winner] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            lfsr      <= SEED;
            cnt       <= '0;
            last      <= IW'(NUM_REQ - 1);
            winner    <= '0;
            gnt       <= '0;
            rnd_out   <= '0;
            rnd_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    gnt       <= '0;
                    rnd_valid <= 1'b0;
                    if (seed_load) begin
                        lfsr <= (seed_in == 8'h00) ? SEED : seed_in;
                    end else if (pick_valid) begin
                        winner <= pick;
                        cnt    <= 8'(STEPS - 1);
                        state  <= STEP;
                        busy   <= 1'b1;
                    end
                end
                STEP: begin
                    lfsr <= lfsr_step(lfsr);
                    if (cnt == 8'd0) begin
                        // Outputs are registered, so present the final shifted value now.
                        state     <= DELIVER;
                        rnd_out   <= lfsr_step(lfsr);
                        rnd_valid <= 1'b1;
                        gnt       <= winner_oh;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                DELIVER: begin
                    gnt       <= '0;
                    rnd_valid <= 1'b0;
                    last      <= winner;
                    state     <= IDLE;
                    busy      <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    gnt       <= '0;
                    rnd_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
